// File: rtl/mac_sched.sv
// mac_sched: two-requester round-robin burst scheduler in front of a shared,
// fixed-latency square-accumulate-sqrt datapath.
//
// A requester holds the grant for one burst (ending on its last flag or after
// MAX_BURST beats), then the scheduler passes through one IDLE cycle and
// re-arbitrates. Every issued beat is tagged {valid, id, last}; the tag travels
// down a LAT-deep shift register so that it meets the datapath result and
// routes it back to its owner.
//
// Ports:
//   clk, reset                  clock, synchronous active-high reset
//   reqN_valid/data/last/ready  requester N sample stream (valid/ready)
//   dp_valid_in, dp_a           beat issued to the datapath
//   dp_valid_out, dp_f          datapath result
//   out_valid/id/last/f         result routed back with owner and last flag
//   err                         sticky result/tag misalignment flag
module mac_sched #(
  parameter int unsigned LAT       = 3,
  parameter int unsigned MAX_BURST = 16
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0_valid,
  input  logic [7:0]  req0_data,
  input  logic        req0_last,
  output logic        req0_ready,
  input  logic        req1_valid,
  input  logic [7:0]  req1_data,
  input  logic        req1_last,
  output logic        req1_ready,
  output logic        dp_valid_in,
  output logic [7:0]  dp_a,
  input  logic        dp_valid_out,
  input  logic [19:0] dp_f,
  output logic        out_valid,
  output logic        out_id,
  output logic        out_last,
  output logic [19:0] out_f,
  output logic        err
);

  localparam logic [4:0] MaxBurstCnt = 5'(MAX_BURST);

  typedef enum logic [1:0] {
    StIdle = 2'd0,
    StGnt0 = 2'd1,
    StGnt1 = 2'd2
  } state_e;

  // Tag layout: {valid, id, last}
  typedef logic [2:0] tag_t;

  state_e          state_q, state_d;
  logic            ptr_q, ptr_d;
  logic [4:0]      cnt_q, cnt_d;
  tag_t [LAT-1:0]  tag_q, tag_d;
  logic            err_q, err_d;

  logic       gnt_id;
  logic       sel_valid;
  logic       sel_last;
  logic [7:0] sel_data;
  logic       beat;
  logic [4:0] cnt_inc;
  tag_t       tag_out;

  // Grant decode and beat detection. Reset masks the beat so a beat presented
  // in a reset cycle is neither issued nor tagged.
  always_comb begin
    gnt_id    = (state_q == StGnt1);
    sel_valid = gnt_id ? req1_valid : req0_valid;
    sel_last  = gnt_id ? req1_last  : req0_last;
    sel_data  = gnt_id ? req1_data  : req0_data;
    beat      = (state_q != StIdle) && sel_valid && !reset;
    cnt_inc   = cnt_q + 5'd1;
  end

  always_comb begin
    req0_ready  = (state_q == StGnt0) && !reset;
    req1_ready  = (state_q == StGnt1) && !reset;
    dp_valid_in = beat;
    dp_a        = beat ? sel_data : 8'd0;
  end

  // Next-state: arbitration, burst counting and release.
  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        cnt_d = 5'd0;
        if (ptr_q ? req1_valid : req0_valid) begin
          state_d = ptr_q ? StGnt1 : StGnt0;
        end else if (ptr_q ? req0_valid : req1_valid) begin
          state_d = ptr_q ? StGnt0 : StGnt1;
        end
      end
      StGnt0, StGnt1: begin
        // A bubble (no beat) holds the grant unchanged.
        if (beat) begin
          cnt_d = cnt_inc;
          // Last and the burst limit share one release, so the pointer flips once.
          if (sel_last || (cnt_inc == MaxBurstCnt)) begin
            state_d = StIdle;
            ptr_d   = ~gnt_id;
            cnt_d   = 5'd0;
          end
        end
      end
      default: begin
        state_d = StIdle;
        cnt_d   = 5'd0;
      end
    endcase
  end

  // Tag pipeline shifts every cycle so stage LAT lines up with dp_valid_out.
  always_comb begin
    tag_d[0] = beat ? {1'b1, gnt_id, sel_last} : 3'b000;
    for (int unsigned i = 1; i < LAT; i++) begin
      tag_d[i] = tag_q[i-1];
    end
  end

  always_comb begin
    tag_out   = tag_q[LAT-1];
    err_d     = err_q | (dp_valid_out != tag_out[2]);
    out_valid = dp_valid_out && tag_out[2] && !reset;
    out_id    = out_valid && tag_out[1];
    out_last  = out_valid && tag_out[0];
    out_f     = out_valid ? dp_f : 20'd0;
    err       = err_q && !reset;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= StIdle;
      ptr_q   <= 1'b0;
      cnt_q   <= 5'd0;
      tag_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
      tag_q   <= tag_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: doc/mac_sched.md
MAC_SCHED -- requirements
Module: mac_sched

Interface
REQ-001 Parameter LAT, default 3: clock edges from a dp_valid_in beat to its dp_valid_out result; legal range 1..8.
REQ-002 Parameter MAX_BURST, default 16: maximum beats granted per burst; legal range 1..31.
REQ-003 Port clk  input  1: single clock; all state updates on its rising edge.
REQ-004 Port reset  input  1: synchronous, active-high reset.
REQ-005 Ports req0_valid / req1_valid  input  1: requester n has a sample offered.
REQ-006 Ports req0_data / req1_data  input  8: unsigned sample.
REQ-007 Ports req0_last / req1_last  input  1: final sample of the requester's burst.
REQ-008 Ports req0_ready / req1_ready  output  1: sample accepted this cycle if valid is also high.
REQ-009 Port dp_valid_in  output  1: beat issued to the shared square-accumulate-sqrt datapath.
REQ-010 Port dp_a  output  8: sample issued to the datapath.
REQ-011 Port dp_valid_out  input  1: datapath result valid.
REQ-012 Port dp_f  input  20: datapath result.
REQ-013 Ports out_valid  output  1 / out_id  output  1 / out_last  output  1 / out_f  output  20: result routed back, tagged with its owner and last flag.
REQ-014 Port err  output  1: sticky flag; datapath result/tag misalignment.

Function
REQ-015 The FSM SHALL have three states: IDLE, GNT0 and GNT1.
REQ-016 In IDLE, both readys SHALL be 0 and no beat SHALL be issued.
REQ-017 In IDLE, the next state SHALL be GNTp if reqp_valid=1, else GNT(other) if req(other)_valid=1, else IDLE; p is the round-robin pointer.
REQ-018 In GNTn, reqn_ready SHALL be 1, the other ready SHALL be 0, and both SHALL be combinational from state only.
REQ-019 A beat SHALL occur when reqn_valid=1 and reqn_ready=1; then dp_valid_in=1 and dp_a=reqn_data combinationally in the same cycle; otherwise dp_valid_in=0 and dp_a=0.
REQ-020 A 5-bit beat counter SHALL increment per beat in GNTn and clear on entry to IDLE.
REQ-021 On a beat with reqn_last=1, or on the beat that makes the count equal MAX_BURST, the next state SHALL be IDLE and the pointer SHALL be set to the other requester.
REQ-022 If last and the MAX_BURST limit coincide, the outcome SHALL be a single release; the pointer flips once.
REQ-023 A GNTn cycle with reqn_valid=0 SHALL hold the grant and issue nothing; a bubble SHALL NOT release the grant.
REQ-024 On each beat, the tag {1, n, reqn_last} SHALL enter a LAT-deep shift register; non-beat cycles SHALL shift in {0,0,0}.
REQ-025 The tag shifts every cycle, so the tag leaving stage LAT SHALL align with dp_valid_out.
REQ-026 out_valid SHALL equal dp_valid_out AND the tag valid bit at stage LAT.
REQ-027 out_id and out_last SHALL equal the stage-LAT tag fields when out_valid=1, else 0.
REQ-028 out_f SHALL equal dp_f when out_valid=1, else 0.
REQ-029 err SHALL set on any cycle where dp_valid_out differs from the stage-LAT tag valid bit, and stay set until reset.
REQ-030 Width rule: dp_f passes through unmodified; no arithmetic in this block beyond the counter.
REQ-031 Maximum throughput SHALL be one beat per cycle within a burst, with exactly one IDLE cycle between bursts.

Reset
REQ-032 While reset=1 at a clock edge: state SHALL become IDLE, the pointer 0, the beat counter 0, all tag stages {0,0,0}, and err 0.
REQ-033 During and after reset, all outputs SHALL be 0 (readys, dp_valid_in, dp_a, out_valid, out_id, out_last, out_f, err).
REQ-034 Reset mid-burst SHALL abandon the burst and discard in-flight tags; the requester must resend.
REQ-035 Reset SHALL take priority over any simultaneous beat.

Verification
REQ-036 Single burst: after reset, req0 sends 3,4 with last on 4, LAT=3 -> req0_ready high 1 cycle after valid; dp_a=3 then 4 on consecutive cycles; out_valid with out_id=0 exactly 3 cycles after each beat; out_last=1 on the second result.
REQ-037 Contention: both valid from reset, 2-beat bursts each -> order GNT0 burst, IDLE, GNT1 burst, IDLE, GNT0; pointer alternates 0,1,0.
REQ-038 MAX_BURST=4: req1 streams 10 beats with no last -> release after beat 4 with out_last=0; re-grant to req1 only after req0 is served if req0 is valid, else immediately after one IDLE cycle.
REQ-039 Bubble: in GNT0, req0_valid low for 2 cycles mid-burst -> grant held, dp_valid_in=0 for those cycles, result count matches beat count.
REQ-040 Misalignment: inject dp_valid_out=1 with no tag at stage LAT -> err=1 on the next cycle and held; out_valid stays 0.
REQ-041 Reset at second beat of a burst -> all outputs 0 the following cycle, in-flight results not flagged out_valid, next grant goes to req0.
